// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - BCD digit types, FSM states and helpers
//
// Purpose: shared types and helpers for the digit-serial BCD adder/subtractor.
//   bcd_digit_t : one packed BCD digit
//   state_t     : IDLE / RUN / DONE controller states
//   BCD_MAX     : largest legal BCD digit value
//   nines_comp  : nine's complement of a digit (9 - d)
// Ports: none (package).

package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  // Illegal digits (>9) wrap; the result is meaningless but err flags it.
  function automatic bcd_digit_t nines_comp(input bcd_digit_t d);
    return BCD_MAX - d;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// rtl/bcd_digit_cell.sv - combinational single-digit BCD adder with carry
//
// Purpose: adds two BCD digits plus a carry-in and produces the decimal
//   sum digit and carry-out.
// Ports:
//   a  in  4  digit of operand A
//   b  in  4  digit of operand B (already nine's-complemented for subtract)
//   ci in  1  carry-in from the next lower digit
//   s  out 4  BCD sum digit
//   co out 1  decimal carry-out

module bcd_digit_cell
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       ci,
  output bcd_digit_t s,
  output logic       co
);

  logic [4:0] t;

  always_comb begin
    t = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
    // Binary sums above 9 are corrected by +6 so the low nibble wraps
    // back into 0..9 and the overflow becomes the decimal carry.
    if (t > 5'd9) begin
      s  = t[3:0] + 4'd6;
      co = 1'b1;
    end else begin
      s  = t[3:0];
      co = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_addsub_seq.sv
// rtl/bcd_addsub_seq.sv - digit-serial packed-BCD adder/subtractor
//
// Purpose: adds or subtracts two NDIGITS-digit packed-BCD operands, DPC
//   digits per clock, rippling the decimal carry through a register
//   between chunks. One operation in flight; valid/ready on both sides.
// Parameters:
//   NDIGITS  operand length in digits (>=1)
//   DPC      digits per cycle, must divide NDIGITS
// Ports:
//   clk        in   1          rising-edge clock
//   rst        in   1          asynchronous active-high reset
//   in_valid   in   1          operands and mode valid
//   in_ready   out  1          high only in IDLE
//   a          in   4*NDIGITS  operand A, digit 0 in [3:0]
//   b          in   4*NDIGITS  operand B, same packing
//   sub        in   1          0: A+B+cin, 1: A-B (ten's complement)
//   cin        in   1          carry-in for add
//   out_valid  out  1          result valid, held until out_ready
//   out_ready  in   1          consumer accepts result
//   sum        out  4*NDIGITS  BCD result mod 10^NDIGITS
//   cout       out  1          add: carry-out; sub: 1 = no borrow
//   err        out  1          an operand digit was > 9 at capture

module bcd_addsub_seq
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 100,
  parameter int DPC     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NDIGITS-1:0] a,
  input  logic [4*NDIGITS-1:0] b,
  input  logic                 sub,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NDIGITS-1:0] sum,
  output logic                 cout,
  output logic                 err
);

  localparam int NCHUNK = NDIGITS / DPC;
  localparam int W      = 4 * NDIGITS;
  localparam int CW     = 4 * DPC;
  localparam int CNTW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(NCHUNK - 1);

  if ((NDIGITS < 1) || (DPC < 1) || ((NDIGITS % DPC) != 0)) begin : g_param_check
    $error("bcd_addsub_seq: NDIGITS must be >= 1 and a multiple of DPC");
  end

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic            carry;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;

  logic [W-1:0]    b_capt;
  logic            bad_digit;

  logic [CW-1:0]   a_chunk;
  logic [CW-1:0]   b_chunk;
  logic [CW-1:0]   s_chunk;
  logic [DPC:0]    carry_chain;

  // Operand conditioning at capture: subtraction becomes A + (nines of B) + 1,
  // and any illegal digit in either operand is noted for err.
  always_comb begin
    b_capt    = b;
    bad_digit = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (sub) begin
        b_capt[4*i +: 4] = nines_comp(b[4*i +: 4]);
      end
      if ((a[4*i +: 4] > BCD_MAX) || (b[4*i +: 4] > BCD_MAX)) begin
        bad_digit = 1'b1;
      end
    end
  end

  // Chunk mux: select the DPC digits addressed by the chunk counter.
  assign a_chunk = a_reg[int'(cnt)*CW +: CW];
  assign b_chunk = b_reg[int'(cnt)*CW +: CW];

  assign carry_chain[0] = carry;

  for (genvar i = 0; i < DPC; i++) begin : g_cell
    bcd_digit_cell u_cell (
      .a  (a_chunk[4*i +: 4]),
      .b  (b_chunk[4*i +: 4]),
      .ci (carry_chain[i]),
      .s  (s_chunk[4*i +: 4]),
      .co (carry_chain[i+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      carry     <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_reg    <= a;
            b_reg    <= b_capt;
            // The +1 of the ten's complement enters as the initial carry.
            carry    <= sub ? 1'b1 : cin;
            err      <= bad_digit;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum[int'(cnt)*CW +: CW] <= s_chunk;
          carry                   <= carry_chain[DPC];
          if (cnt == LAST) begin
            cout      <= carry_chain[DPC];
            cnt       <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_addsub_seq.sv
// tb/tb_bcd_addsub_seq.sv - self-checking bench for bcd_addsub_seq

module tb_bcd_addsub_seq;

  localparam int ND_S  = 8;
  localparam int NCH_S = 4;
  localparam int ND_B  = 100;
  localparam int NCH_B = 25;

  typedef struct {
    logic [399:0] sum;
    logic         cout;
    logic         err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid_s, in_ready_s, sub_s, cin_s, out_valid_s, out_ready_s, cout_s, err_s;
  logic [31:0] a_s, b_s, sum_s;

  logic         in_valid_b, in_ready_b, sub_b, cin_b, out_valid_b, out_ready_b, cout_b, err_b;
  logic [399:0] a_b, b_b, sum_b;

  exp_t q_s[$];
  exp_t q_b[$];
  int   compared   = 0;
  int   mismatched = 0;

  bcd_addsub_seq #(.NDIGITS(ND_S), .DPC(2)) u_dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .a(a_s), .b(b_s), .sub(sub_s), .cin(cin_s),
    .out_valid(out_valid_s), .out_ready(out_ready_s),
    .sum(sum_s), .cout(cout_s), .err(err_s)
  );

  bcd_addsub_seq #(.NDIGITS(ND_B), .DPC(4)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .a(a_b), .b(b_b), .sub(sub_b), .cin(cin_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .sum(sum_b), .cout(cout_b), .err(err_b)
  );

  task automatic chk(input string tag, input logic [399:0] obs, input logic [399:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag, input string obs, input string exp);
    compared++;
    mismatched++;
    $error("FAIL %s: observed %s expected %s", tag, obs, exp);
  endtask

  // Reference: plain decimal digit arithmetic, subtraction done with borrows.
  function automatic exp_t model(input int nd, input logic [399:0] a, input logic [399:0] b,
                                 input logic s, input logic c);
    exp_t r;
    int   t;
    int   k;
    r.sum = '0;
    r.err = 1'b0;
    k     = s ? 0 : int'(c);
    for (int i = 0; i < nd; i++) begin
      int da;
      int db;
      da = int'(a[4*i +: 4]);
      db = int'(b[4*i +: 4]);
      if (da > 9 || db > 9) r.err = 1'b1;
      if (!s) begin
        t = da + db + k;
        k = (t >= 10) ? 1 : 0;
        if (t >= 10) t = t - 10;
      end else begin
        t = da - db - k;
        k = (t < 0) ? 1 : 0;
        if (t < 0) t = t + 10;
      end
      r.sum[4*i +: 4] = 4'(t);
    end
    r.cout = s ? (k == 0) : (k == 1);
    return r;
  endfunction

  function automatic logic [399:0] rand_bcd();
    logic [399:0] r;
    for (int i = 0; i < 100; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  task automatic start_s(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic c);
    @(negedge clk);
    chk_i({tag, "_in_ready"}, int'(in_ready_s), 1);
    a_s = a; b_s = b; sub_s = s; cin_s = c; in_valid_s = 1'b1;
    q_s.push_back(model(ND_S, {368'b0, a}, {368'b0, b}, s, c));
    @(posedge clk);
    #1;
    in_valid_s = 1'b0;
  endtask

  task automatic wait_s(input string tag, output bit ok);
    int lat;
    lat = 0;
    ok  = 1'b0;
    while (!ok && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid_s) ok = 1'b1;
    end
    if (!ok) fail_now({tag, "_wait"}, "no out_valid", "out_valid");
    else chk_i({tag, "_latency"}, lat, NCH_S);
  endtask

  task automatic check_s(input string tag);
    exp_t e;
    if (q_s.size() == 0) begin
      fail_now({tag, "_scoreboard"}, "unexpected result", "no result");
    end else begin
      e = q_s.pop_front();
      if (!e.err) begin
        chk({tag, "_sum"}, 400'(sum_s), e.sum);
        chk_i({tag, "_cout"}, int'(cout_s), int'(e.cout));
      end
      chk_i({tag, "_err"}, int'(err_s), int'(e.err));
    end
  endtask

  task automatic op_s(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic s, input logic c);
    bit ok;
    start_s(tag, a, b, s, c);
    wait_s(tag, ok);
    if (ok) begin
      check_s(tag);
      @(posedge clk);
      #1;
      chk_i({tag, "_release"}, int'({out_valid_s, in_ready_s}), 1);
    end
  endtask

  task automatic op_b(input string tag, input logic [399:0] a, input logic [399:0] b,
                      input logic s, input logic c);
    exp_t e;
    int   lat;
    bit   ok;
    @(negedge clk);
    a_b = a; b_b = b; sub_b = s; cin_b = c; in_valid_b = 1'b1;
    q_b.push_back(model(ND_B, a, b, s, c));
    @(posedge clk);
    #1;
    in_valid_b = 1'b0;
    lat = 0;
    ok  = 1'b0;
    while (!ok && lat < 500) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid_b) ok = 1'b1;
    end
    if (!ok) begin
      fail_now({tag, "_wait"}, "no out_valid", "out_valid");
    end else begin
      chk_i({tag, "_latency"}, lat, NCH_B);
      e = q_b.pop_front();
      chk({tag, "_sum"}, sum_b, e.sum);
      chk_i({tag, "_cout"}, int'(cout_b), int'(e.cout));
      chk_i({tag, "_err"}, int'(err_b), int'(e.err));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed still running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hold_sum;
    logic        hold_cout;
    bit          ok;
    int          seen;

    rst = 1'b1;
    in_valid_s = 1'b0; a_s = '0; b_s = '0; sub_s = 1'b0; cin_s = 1'b0; out_ready_s = 1'b1;
    in_valid_b = 1'b0; a_b = '0; b_b = '0; sub_b = 1'b0; cin_b = 1'b0; out_ready_b = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_sum", 400'(sum_s), 400'(0));
    chk_i("rst_flags", int'({cout_s, err_s, out_valid_s, in_ready_s}), 1);
    chk_i("rst_big_in_ready", int'(in_ready_b), 1);
    rst = 1'b0;

    op_s("t1_add_wrap", 32'h99999999, 32'h00000001, 1'b0, 1'b0);
    op_s("t2_sub_borrow", 32'h00000005, 32'h00000007, 1'b1, 1'b0);
    op_s("t3_sub", 32'h12345678, 32'h00345678, 1'b1, 1'b0);
    op_s("t3_add_cin", 32'h00000009, 32'h00000009, 1'b0, 1'b1);
    op_s("t_add_max", 32'h99999999, 32'h99999999, 1'b0, 1'b1);
    op_s("t_sub_equal", 32'h55443322, 32'h55443322, 1'b1, 1'b1);
    op_s("t4_bad_digit", 32'h0000000A, 32'h00000001, 1'b0, 1'b0);
    op_s("t4_recover", 32'h00000001, 32'h00000002, 1'b0, 1'b0);

    // Consumer stalls: result must hold and new requests must be ignored.
    out_ready_s = 1'b0;
    start_s("t5_stall", 32'h24681357, 32'h13572468, 1'b0, 1'b0);
    wait_s("t5_stall", ok);
    if (ok) begin
      check_s("t5_stall");
      hold_sum  = sum_s;
      hold_cout = cout_s;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        a_s = 32'h11111111; b_s = 32'h11111111; in_valid_s = i[0];
        @(posedge clk);
        #1;
        chk("t5_hold_sum", 400'(sum_s), 400'(hold_sum));
        chk_i("t5_hold_state", int'({cout_s, out_valid_s, in_ready_s}), int'({hold_cout, 2'b10}));
      end
      @(negedge clk);
      in_valid_s  = 1'b0;
      out_ready_s = 1'b1;
      @(posedge clk);
      #1;
      chk_i("t5_release", int'({out_valid_s, in_ready_s}), 1);
      seen = 0;
      repeat (8) begin
        @(posedge clk);
        #1;
        if (out_valid_s) seen++;
      end
      chk_i("t5_no_ghost_result", seen, 0);
      chk_i("t5_queue_empty", q_s.size(), 0);
    end
    out_ready_s = 1'b1;

    // Reset in the middle of an operation.
    start_s("t6_abort", 32'h11112222, 32'h33334444, 1'b0, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    chk("t6_rst_sum", 400'(sum_s), 400'(0));
    chk_i("t6_rst_flags", int'({cout_s, err_s, out_valid_s, in_ready_s}), 1);
    void'(q_s.pop_back());
    @(negedge clk);
    rst = 1'b0;
    op_s("t6_after_rst", 32'h11111111, 32'h22222222, 1'b0, 1'b0);

    // Default-sized instance: directed carry chain plus random operands.
    op_b("big_all9_plus1", {100{4'h9}}, 400'h1, 1'b0, 1'b0);
    op_b("big_small_minus_big", 400'h3, 400'h8, 1'b1, 1'b0);
    for (int n = 0; n < 8; n++) begin
      op_b($sformatf("big_rand%0d", n), rand_bcd(), rand_bcd(),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
